cart_bus_arbiter: RTL and testbench

- Sequences and shares the single cart_iface ROM/RAM port between NREQ requesters: startup screen generator, DMG+ splash generator and SPI cart bridge.
- Replaces the static combinational rom_rd/rom_wr/rom_a mux.
- Each requester issues a held read or write request. The arbiter grants one requester, pulses rom_rd or rom_wr once, and tracks rom_bsy to completion. It then returns read data with a one-cycle done pulse.
- Includes a timeout so a dead cart cannot hang boot.

---
 rtl/cart_bus_arbiter_if.sv | 32 +++
 rtl/cart_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cart_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_bus_arbiter_if.sv
// Requester and cart_iface signal bundle for cart_bus_arbiter.
// The arbiter connects through the slave modport; the requesters and the
// cart_iface model connect through the master modport.
interface cart_bus_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]      req_en;
   logic [NREQ-1:0]      req_rd;
   logic [NREQ-1:0]      req_wr;
   logic [16*NREQ-1:0]   req_addr;
   logic [8*NREQ-1:0]    req_wdata;
   logic [NREQ-1:0]      req_done;
   logic [NREQ-1:0]      req_err;
   logic [7:0]           rdata;
   logic [NREQ-1:0]      grant;
   logic [15:0]          rom_a;
   logic [7:0]           rom_din;
   logic                 rom_rd;
   logic                 rom_wr;
   logic                 rom_bsy;
   logic [7:0]           rom_dout;

   modport slave (
      input  req_en, req_rd, req_wr, req_addr, req_wdata, rom_bsy, rom_dout,
      output req_done, req_err, rdata, grant, rom_a, rom_din, rom_rd, rom_wr
   );

   modport master (
      output req_en, req_rd, req_wr, req_addr, req_wdata, rom_bsy, rom_dout,
      input  req_done, req_err, rdata, grant, rom_a, rom_din, rom_rd, rom_wr
   );
endinterface

// File: rtl/cart_bus_arbiter.sv
// Shares the single cart_iface ROM/RAM port between NREQ requesters.
// One transaction at a time: pick a winner in IDLE, strobe once in ISSUE,
// follow rom_bsy through WAIT_HI/WAIT_LO, then pulse done for one cycle.
// A timeout in WAIT_LO keeps a dead cart from hanging boot.
module cart_bus_arbiter #(
   parameter int NREQ     = 3,
   parameter int ARB_MODE = 0,
   parameter int START_TO = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic               clk_8m,
   input  logic               rst,
   cart_bus_arbiter_if.slave  bus
);
   localparam int CNT_MAX = (START_TO > TIMEOUT) ? START_TO : TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [IW-1:0]   win, win_nxt;
   logic [IW-1:0]   ptr, ptr_nxt;
   logic            is_wr, is_wr_nxt;
   logic            err, err_nxt;
   logic [15:0]     addr_q, addr_nxt;
   logic [7:0]      wdata_q, wdata_nxt;
   logic [7:0]      rdata_q, rdata_nxt;

   logic [NREQ-1:0] pending;
   logic            sel_found;
   logic [IW-1:0]   sel_idx;
   logic [NREQ-1:0] win_oh;

   assign pending = bus.req_en & (bus.req_rd | bus.req_wr);
   assign win_oh  = ONE << win;

   // Winner selection: lowest pending index, or first pending after ptr
   always_comb begin : sel_p
      int j;
      j         = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      if (ARB_MODE == 0) begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
               sel_found = 1'b1;
               sel_idx   = IW'(i);
            end
         end
      end else begin
         // walk backwards so the nearest index after ptr is written last
         for (int k = NREQ; k >= 1; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (pending[j]) begin
               sel_found = 1'b1;
               sel_idx   = IW'(j);
            end
         end
      end
   end

   // State register and transaction latches
   always_ff @(posedge clk_8m) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         win     <= '0;
         ptr     <= IW'(NREQ - 1);
         is_wr   <= 1'b0;
         err     <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         win     <= win_nxt;
         ptr     <= ptr_nxt;
         is_wr   <= is_wr_nxt;
         err     <= err_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         rdata_q <= rdata_nxt;
      end
   end

   // Next-state logic; read data is captured on the edge into DONE so it is
   // already valid while req_done is high
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      win_nxt   = win;
      ptr_nxt   = ptr;
      is_wr_nxt = is_wr;
      err_nxt   = err;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      rdata_nxt = rdata_q;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_nxt = ISSUE;
               win_nxt   = sel_idx;
               ptr_nxt   = sel_idx;
               // write wins when rd and wr are both set
               is_wr_nxt = bus.req_wr[sel_idx];
               err_nxt   = 1'b0;
               addr_nxt  = bus.req_addr[int'(sel_idx)*16 +: 16];
               wdata_nxt = bus.req_wdata[int'(sel_idx)*8 +: 8];
            end
         end
         ISSUE: begin
            state_nxt = WAIT_HI;
            cnt_nxt   = '0;
         end
         WAIT_HI: begin
            if (bus.rom_bsy) begin
               state_nxt = WAIT_LO;
               cnt_nxt   = '0;
            end else if (cnt == CW'(START_TO - 1)) begin
               // cart never went busy: treat as a zero-latency access
               state_nxt = DONE;
               if (!is_wr) rdata_nxt = bus.rom_dout;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_LO: begin
            if (!bus.rom_bsy) begin
               state_nxt = DONE;
               if (!is_wr) rdata_nxt = bus.rom_dout;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_nxt = DONE;
               err_nxt   = 1'b1;
               if (!is_wr) rdata_nxt = 8'hFF;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs decode directly from registered state, so none depend on inputs
   always_comb begin
      bus.grant    = (state != IDLE) ? win_oh : '0;
      bus.req_done = (state == DONE) ? win_oh : '0;
      bus.req_err  = (state == DONE && err) ? win_oh : '0;
      bus.rom_rd   = (state == ISSUE) && !is_wr;
      bus.rom_wr   = (state == ISSUE) && is_wr;
      bus.rom_a    = addr_q;
      bus.rom_din  = wdata_q;
      bus.rdata    = rdata_q;
   end
endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Scoreboard bench for cart_bus_arbiter: one fixed-priority and one
// round-robin instance, exercised one at a time. Stimulus pushes expected
// strobes and completions; a negedge monitor pops and compares.
module tb_cart_bus_arbiter;
   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_err;

   logic        sel;          // 0: drive fixed-priority dut, 1: round-robin dut
   logic [2:0]  req_en, req_rd, req_wr;
   logic [47:0] req_addr;
   logic [23:0] req_wdata;
   logic        rom_bsy;
   logic [7:0]  rom_dout;
   logic [2:0]  cur_done;
   logic [7:0]  last_rd [2];

   typedef struct {
      int         dut;
      int         idx;
      bit         err;
      logic [7:0] rdata;
      int         cyc;
   } done_t;

   typedef struct {
      int          dut;
      bit          wr;
      logic [15:0] a;
      logic [7:0]  din;
      int          cyc;
   } strb_t;

   done_t dq[$];
   strb_t sq[$];

   cart_bus_arbiter_if #(.NREQ(3)) bus_fp ();
   cart_bus_arbiter_if #(.NREQ(3)) bus_rr ();

   cart_bus_arbiter #(.NREQ(3), .ARB_MODE(0), .START_TO(4), .TIMEOUT(255)) dut_fp (
      .clk_8m (clk),
      .rst    (rst),
      .bus    (bus_fp.slave)
   );

   cart_bus_arbiter #(.NREQ(3), .ARB_MODE(1), .START_TO(4), .TIMEOUT(255)) dut_rr (
      .clk_8m (clk),
      .rst    (rst),
      .bus    (bus_rr.slave)
   );

   assign bus_fp.req_en    = req_en;
   assign bus_fp.req_rd    = sel ? 3'b000 : req_rd;
   assign bus_fp.req_wr    = sel ? 3'b000 : req_wr;
   assign bus_fp.req_addr  = req_addr;
   assign bus_fp.req_wdata = req_wdata;
   assign bus_fp.rom_bsy   = rom_bsy;
   assign bus_fp.rom_dout  = rom_dout;
   assign bus_rr.req_en    = req_en;
   assign bus_rr.req_rd    = sel ? req_rd : 3'b000;
   assign bus_rr.req_wr    = sel ? req_wr : 3'b000;
   assign bus_rr.req_addr  = req_addr;
   assign bus_rr.req_wdata = req_wdata;
   assign bus_rr.rom_bsy   = rom_bsy;
   assign bus_rr.rom_dout  = rom_dout;
   assign cur_done = sel ? bus_rr.req_done : bus_fp.req_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_done(input int d, input int idx, input bit e, input logic [7:0] rd, input int c);
      done_t x;
      x.dut = d; x.idx = idx; x.err = e; x.rdata = rd; x.cyc = c;
      dq.push_back(x);
   endtask

   task automatic push_strb(input int d, input bit wr, input logic [15:0] a, input logic [7:0] din, input int c);
      strb_t x;
      x.dut = d; x.wr = wr; x.a = a; x.din = din; x.cyc = c;
      sq.push_back(x);
   endtask

   task automatic mon_done(input int d, input logic [2:0] dn, input logic [2:0] er,
                           input logic [2:0] gt, input logic [7:0] rd);
      done_t e;
      logic [2:0] one;
      logic [2:0] oh;
      logic [2:0] eoh;
      if (dn == 3'b000) return;
      n_cmp++;
      if (dq.size() == 0) begin
         n_err++;
         $display("FAIL done_unexpected dut=%0d cyc=%0d done=%b err=%b", d, cyc, dn, er);
         return;
      end
      e   = dq.pop_front();
      one = 3'b001;
      oh  = one << e.idx;
      eoh = e.err ? oh : 3'b000;
      if (d != e.dut || dn !== oh || gt !== oh || er !== eoh || rd !== e.rdata || cyc != e.cyc) begin
         n_err++;
         $display("FAIL done dut=%0d cyc=%0d done=%b err=%b grant=%b rdata=%h / expected dut=%0d cyc=%0d done=%b err=%b rdata=%h",
                  d, cyc, dn, er, gt, rd, e.dut, e.cyc, oh, eoh, e.rdata);
      end
   endtask

   task automatic mon_strb(input int d, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [7:0] din);
      strb_t e;
      if (!(rd || wr)) return;
      n_cmp++;
      if (sq.size() == 0) begin
         n_err++;
         $display("FAIL strobe_unexpected dut=%0d cyc=%0d rd=%b wr=%b a=%h", d, cyc, rd, wr, a);
         return;
      end
      e = sq.pop_front();
      if (d != e.dut || wr !== e.wr || rd !== !e.wr || a !== e.a || din !== e.din || cyc != e.cyc) begin
         n_err++;
         $display("FAIL strobe dut=%0d cyc=%0d rd=%b wr=%b a=%h din=%h / expected dut=%0d cyc=%0d wr=%b a=%h din=%h",
                  d, cyc, rd, wr, a, din, e.dut, e.cyc, e.wr, e.a, e.din);
      end
   endtask

   // Monitor: compare every completion and every strobe against the queues
   always @(negedge clk) begin
      if (!rst) begin
         mon_done(0, bus_fp.req_done, bus_fp.req_err, bus_fp.grant, bus_fp.rdata);
         mon_done(1, bus_rr.req_done, bus_rr.req_err, bus_rr.grant, bus_rr.rdata);
         mon_strb(0, bus_fp.rom_rd, bus_fp.rom_wr, bus_fp.rom_a, bus_fp.rom_din);
         mon_strb(1, bus_rr.rom_rd, bus_rr.rom_wr, bus_rr.rom_a, bus_rr.rom_din);
      end
   end

   task automatic wait_done(input int idx, input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (cur_done[idx]) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_done idx=%0d: no done within %0d cycles", idx, budget);
      end
   endtask

   task automatic chk_zero(input string nm);
      logic [87:0] a_fp;
      logic [87:0] a_rr;
      a_fp = {bus_fp.grant, bus_fp.req_done, bus_fp.req_err, bus_fp.rom_rd, bus_fp.rom_wr,
              bus_fp.rom_a, bus_fp.rom_din, bus_fp.rdata, 39'd0};
      a_rr = {bus_rr.grant, bus_rr.req_done, bus_rr.req_err, bus_rr.rom_rd, bus_rr.rom_wr,
              bus_rr.rom_a, bus_rr.rom_din, bus_rr.rdata, 39'd0};
      n_cmp++;
      if (a_fp !== 88'd0 || a_rr !== 88'd0) begin
         n_err++;
         $display("FAIL %s outputs fp=%h rr=%h, required all zero", nm, a_fp, a_rr);
      end
   endtask

   task automatic set_slice(input int i, input logic [15:0] a, input logic [7:0] wd);
      req_addr[16*i +: 16] = a;
      req_wdata[8*i +: 8]  = wd;
   endtask

   initial begin
      int c;
      n_cmp = 0; n_err = 0;
      rst = 1'b1; sel = 1'b0;
      req_en = 3'b000; req_rd = 3'b000; req_wr = 3'b000;
      req_addr = '0; req_wdata = '0;
      rom_bsy = 1'b0; rom_dout = 8'h00;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // single read, no busy: strobe at +1, done at +2+START_TO
      c = cyc;
      rom_dout = 8'h3C; req_en = 3'b111;
      set_slice(0, 16'h0104, 8'h00);
      req_rd = 3'b001;
      push_strb(0, 1'b0, 16'h0104, 8'h00, c + 1);
      push_done(0, 0, 1'b0, 8'h3C, c + 6);
      last_rd[0] = 8'h3C;
      wait_done(0, 20);
      req_rd = 3'b000;
      @(negedge clk);

      // write with busy high cycles 2..9: done the cycle after busy falls
      c = cyc;
      set_slice(2, 16'hA000, 8'h5A);
      rom_dout = 8'h99;
      req_wr = 3'b100;
      push_strb(0, 1'b1, 16'hA000, 8'h5A, c + 1);
      push_done(0, 2, 1'b0, last_rd[0], c + 11);
      repeat (2) @(negedge clk);
      rom_bsy = 1'b1;
      repeat (8) @(negedge clk);
      rom_bsy = 1'b0;
      wait_done(2, 20);
      req_wr = 3'b000;
      @(negedge clk);

      // rd and wr together execute as a write
      c = cyc;
      set_slice(1, 16'h1234, 8'h77);
      req_rd = 3'b010; req_wr = 3'b010;
      push_strb(0, 1'b1, 16'h1234, 8'h77, c + 1);
      push_done(0, 1, 1'b0, last_rd[0], c + 6);
      wait_done(1, 20);
      req_rd = 3'b000; req_wr = 3'b000;
      @(negedge clk);

      // fixed priority: 0 wins while enabled, then 1
      c = cyc;
      rom_dout = 8'h11;
      set_slice(0, 16'h0100, 8'h00);
      set_slice(1, 16'h0200, 8'h77);
      set_slice(2, 16'h0300, 8'h5A);
      req_rd = 3'b111;
      for (int k = 0; k < 3; k++) begin
         push_strb(0, 1'b0, 16'h0100, 8'h00, c + 1 + 7*k);
         push_done(0, 0, 1'b0, 8'h11, c + 6 + 7*k);
      end
      push_strb(0, 1'b0, 16'h0200, 8'h77, c + 22);
      push_done(0, 1, 1'b0, 8'h11, c + 27);
      last_rd[0] = 8'h11;
      for (int k = 0; k < 3; k++) wait_done(0, 20);
      req_en = 3'b110;
      wait_done(1, 20);
      req_rd = 3'b000; req_en = 3'b111;
      @(negedge clk);

      // timeout: busy stuck high, 255 WAIT_LO cycles then done+err, rdata FF
      c = cyc;
      rom_bsy = 1'b1;
      req_rd = 3'b001;
      push_strb(0, 1'b0, 16'h0100, 8'h00, c + 1);
      push_done(0, 0, 1'b1, 8'hFF, c + 258);
      wait_done(0, 300);
      req_rd = 3'b000; rom_bsy = 1'b0;
      @(negedge clk);

      // normal read after timeout
      c = cyc;
      rom_dout = 8'h42;
      req_rd = 3'b010;
      push_strb(0, 1'b0, 16'h0200, 8'h77, c + 1);
      push_done(0, 1, 1'b0, 8'h42, c + 6);
      wait_done(1, 20);
      req_rd = 3'b000;
      @(negedge clk);

      // round-robin from reset pointer: 0,1,2,0
      sel = 1'b1;
      c = cyc;
      rom_dout = 8'h5C;
      req_rd = 3'b111;
      push_strb(1, 1'b0, 16'h0100, 8'h00, c + 1);
      push_done(1, 0, 1'b0, 8'h5C, c + 6);
      push_strb(1, 1'b0, 16'h0200, 8'h77, c + 8);
      push_done(1, 1, 1'b0, 8'h5C, c + 13);
      push_strb(1, 1'b0, 16'h0300, 8'h5A, c + 15);
      push_done(1, 2, 1'b0, 8'h5C, c + 20);
      push_strb(1, 1'b0, 16'h0100, 8'h00, c + 22);
      push_done(1, 0, 1'b0, 8'h5C, c + 27);
      wait_done(0, 20);
      wait_done(1, 20);
      wait_done(2, 20);
      wait_done(0, 20);
      req_rd = 3'b000;
      @(negedge clk);

      // reset in WAIT_LO: no done, everything zero next cycle
      c = cyc;
      rom_bsy = 1'b1;
      req_rd = 3'b010;
      push_strb(1, 1'b0, 16'h0200, 8'h77, c + 1);
      repeat (5) @(negedge clk);
      rst = 1'b1; req_rd = 3'b000; rom_bsy = 1'b0;
      @(negedge clk);
      chk_zero("reset_midop");
      rst = 1'b0;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
      @(negedge clk);

      // round-robin after reset with req_en=101: 0,2,0
      c = cyc;
      rom_dout = 8'hA7;
      req_en = 3'b101;
      req_rd = 3'b111;
      push_strb(1, 1'b0, 16'h0100, 8'h00, c + 1);
      push_done(1, 0, 1'b0, 8'hA7, c + 6);
      push_strb(1, 1'b0, 16'h0300, 8'h5A, c + 8);
      push_done(1, 2, 1'b0, 8'hA7, c + 13);
      push_strb(1, 1'b0, 16'h0100, 8'h00, c + 15);
      push_done(1, 0, 1'b0, 8'hA7, c + 20);
      wait_done(0, 20);
      wait_done(2, 20);
      wait_done(0, 20);
      req_rd = 3'b000;
      repeat (5) @(negedge clk);

      n_cmp++;
      if (dq.size() != 0) begin
         n_err++;
         $display("FAIL done_queue_drain: %0d left, required 0", dq.size());
      end
      n_cmp++;
      if (sq.size() != 0) begin
         n_err++;
         $display("FAIL strobe_queue_drain: %0d left, required 0", sq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
